// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM among NUM_REQ requesters (instruction
// fetch, load/store, debug, ...). Each requester has a valid/ready request
// channel. Completion is signalled by a one-cycle response pulse to the
// requester that owns the transaction. Only one transaction is in flight at a
// time.
//
// Transaction flow:  IDLE/RESP --handshake--> ISSUE --(read)--> WAIT --> RESP
//                                                   --(write)-----------> RESP
// RESP can accept the next request in the same cycle, so back-to-back
// transactions overlap their RESP and grant cycles.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> rotating priority. The search starts at a
//                                    pointer that moves past each winner.
//                       undefined -> fixed priority (index 0 highest), no
//                                    pointer state.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   ADDR_W    byte-address width
//   DATA_W    RAM word width
//   READ_LAT  RAM read latency in cycles from the address cycle (1..4)
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (one-hot or zero, combinational)
//   req_we         per-requester write flag (1 = write)
//   req_addr       packed byte addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata      packed write data, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid      one-cycle completion pulse to the owning requester
//   rsp_rdata      read data with rsp_valid (0 on a write acknowledge)
//   busy           a transaction is in flight
//   ram_address    RAM word address (byte address with bits [1:0] dropped)
//   ram_data       RAM write data
//   ram_wren       RAM write enable, one cycle per write
//   ram_q          RAM read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic [ADDR_W-3:0]           ram_address,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_wren,
  input  logic [DATA_W-1:0]           ram_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_LSB = NUM_REQ'(1);

  // WAIT covers READ_LAT-1 cycles. The counter is loaded with READ_LAT-2 and
  // leaves WAIT when it reads zero. For READ_LAT = 1, WAIT is skipped.
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_t               state;
  logic [NUM_REQ-1:0]   own_p0;     // one-hot owner of the in-flight transaction
  logic                 we_p0;      // in-flight transaction is a write
  logic [1:0]           wait_cnt;

  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 handshake;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 unused_addr_bits;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    return v & (~v + ONE_LSB);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [2*NUM_REQ-1:0] vld_rot2;
  logic [2*NUM_REQ-1:0] gnt_rot2;
  logic [NUM_REQ-1:0]   gnt_rot;
  logic                 unused_rr_bits;

  // Pointer value after a grant: one past the winner, wrapping to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        p = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    return p;
  endfunction

  // Rotate the request vector so that the pointer position sits at bit 0,
  // take the lowest valid bit, then rotate the grant back. Doubling the
  // vector turns the rotations into plain shifts.
  always_comb begin
    vld_rot2 = {req_valid, req_valid} >> rr_ptr;
    gnt_rot  = lowest_set(vld_rot2[NUM_REQ-1:0]);
    gnt_rot2 = {gnt_rot, gnt_rot} << rr_ptr;
    grant    = gnt_rot2[2*NUM_REQ-1:NUM_REQ];
  end

  assign unused_rr_bits = ^{vld_rot2[2*NUM_REQ-1:NUM_REQ], gnt_rot2[NUM_REQ-1:0]};
`else
  assign grant = lowest_set(req_valid);
`endif

  // Requests are accepted only in IDLE or RESP, never while reset is asserted.
  assign accept    = reset_n && ((state == S_IDLE) || (state == S_RESP));
  assign req_ready = accept ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  // Payload of the winning requester.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Word access only: the byte offset is discarded.
  assign unused_addr_bits = ^sel_addr[1:0];

  // Read data comes straight from the RAM in the RESP cycle. A register here
  // would add a cycle to the read latency.
  assign rsp_rdata = ((state == S_RESP) && !we_p0) ? ram_q : '0;

  // ---- stage p0: grant/latch -> RAM issue -> wait -> response ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      own_p0      <= '0;
      we_p0       <= 1'b0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      rsp_valid   <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      ram_wren  <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (handshake) begin
            own_p0      <= grant;
            we_p0       <= sel_we;
            ram_address <= sel_addr[ADDR_W-1:2];
            ram_data    <= sel_wdata;
            ram_wren    <= sel_we;
            busy        <= 1'b1;
            state       <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr      <= next_ptr(grant);
`endif
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (we_p0 || (READ_LAT == 1)) begin
            rsp_valid <= own_p0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_valid <= own_p0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances with behavioural RAMs: dut_a uses READ_LAT=1 and
// dut_b uses READ_LAT=3. The stimulus process records each expected response
// (cycle, owner, data) in a per-instance queue at handshake time. One monitor
// per instance pops and compares the entry whenever rsp_valid is seen.
// Inputs change 1 time unit after posedge. Outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [1:0]  own;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;

  logic        rstn_a, rstn_b;
  logic [1:0]  vld_a, rdy_a, we_a, rspv_a;
  logic [1:0]  vld_b, rdy_b, we_b, rspv_b;
  logic [63:0] addr_a, wd_a, addr_b, wd_b;
  logic [31:0] rdata_a, ramd_a, q_a;
  logic [31:0] rdata_b, ramd_b, q_b;
  logic [29:0] ramad_a, ramad_b;
  logic        busy_a, wren_a, busy_b, wren_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pb1, pb2;
  logic        unused_hi;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut_a (
    .clk(clk), .reset_n(rstn_a), .req_valid(vld_a), .req_ready(rdy_a),
    .req_we(we_a), .req_addr(addr_a), .req_wdata(wd_a), .rsp_valid(rspv_a),
    .rsp_rdata(rdata_a), .busy(busy_a), .ram_address(ramad_a),
    .ram_data(ramd_a), .ram_wren(wren_a), .ram_q(q_a)
  );

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut_b (
    .clk(clk), .reset_n(rstn_b), .req_valid(vld_b), .req_ready(rdy_b),
    .req_we(we_b), .req_addr(addr_b), .req_wdata(wd_b), .rsp_valid(rspv_b),
    .rsp_rdata(rdata_b), .busy(busy_b), .ram_address(ramad_b),
    .ram_data(ramd_b), .ram_wren(wren_b), .ram_q(q_b)
  );

  assign unused_hi = ^{ramad_a[29:8], ramad_b[29:8]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM A: latency 1. Preloaded on the first edge.
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem_a[4] <= 32'hDEADBEEF;
      mem_a[5] <= 32'h55AA55AA;
    end else if (wren_a) begin
      mem_a[ramad_a[7:0]] <= ramd_a;
    end
    q_a <= mem_a[ramad_a[7:0]];
  end

  // RAM B: latency 3.
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem_b[4] <= 32'h12345678;
      mem_b[5] <= 32'h0BADF00D;
    end else if (wren_b) begin
      mem_b[ramad_b[7:0]] <= ramd_b;
    end
    pb1 <= mem_b[ramad_b[7:0]];
    pb2 <= pb1;
    q_b <= pb2;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitors: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cyc > 2 && rspv_a != 2'b00) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", rspv_a, 0);
      else begin
        ea = qa.pop_front();
        chk("a_rsp_cycle", cyc, ea.cyc);
        chk("a_rsp_owner", rspv_a, ea.own);
        chk("a_rsp_data", rdata_a, ea.data);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 2 && rspv_b != 2'b00) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", rspv_b, 0);
      else begin
        eb = qb.pop_front();
        chk("b_rsp_cycle", cyc, eb.cyc);
        chk("b_rsp_owner", rspv_b, eb.own);
        chk("b_rsp_data", rdata_b, eb.data);
      end
    end
  end

  // Raise a request, wait (bounded) for its ready, queue the expected
  // response, then drop valid one unit after the handshake edge.
  task automatic hs(input bit b, input int idx, input bit we, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_d, input bit push,
                    output int t, output int waited);
    bit   got;
    exp_t e;
    if (!b) begin
      we_a[idx] = we; addr_a[idx*32 +: 32] = addr; wd_a[idx*32 +: 32] = wd; vld_a[idx] = 1'b1;
    end else begin
      we_b[idx] = we; addr_b[idx*32 +: 32] = addr; wd_b[idx*32 +: 32] = wd; vld_b[idx] = 1'b1;
    end
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if ((b ? rdy_b[idx] : rdy_a[idx]) == 1'b1) got = 1'b1;
      else waited++;
    end
    chk("hs_ready_seen", got, 1);
    t = cyc;
    if (push && got) begin
      e.cyc  = t + (we ? 2 : 1 + (b ? 3 : 1));
      e.own  = 2'b01 << idx;
      e.data = we ? 32'h0 : exp_d;
      if (b) qb.push_back(e);
      else   qa.push_back(e);
    end
    @(posedge clk); #1;
    if (!b) vld_a[idx] = 1'b0;
    else    vld_b[idx] = 1'b0;
  endtask

  initial begin
    int   t, w, n, prev, win_act;
    bit   got;
    int   win [4];
    int   rem [2];
    exp_t e;

`ifdef ARB_ROUND_ROBIN_EN
    win = '{0, 1, 0, 0};
`else
    win = '{0, 0, 0, 1};
`endif

    vld_a = '0; we_a = '0; addr_a = '0; wd_a = '0;
    vld_b = '0; we_b = '0; addr_b = '0; wd_b = '0;
    rstn_a = 1'b0; rstn_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy_a, 0);
    chk("rst_rsp_valid", rspv_a, 0);
    chk("rst_wren", wren_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ram_address", ramad_a, 0);
    chk("rst_ram_data", ramd_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_b_busy", busy_b, 0);
    @(posedge clk); #1;
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(negedge clk);
    chk("idle_no_req_ready", rdy_a, 0);
    chk("idle_no_req_busy", busy_a, 0);
    @(posedge clk); #1;

    // Single read, latency 1
    hs(0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, t, w);
    chk("t1_ready_at_T", w, 0);
    @(negedge clk);
    chk("t1_ram_address", ramad_a, 4);
    chk("t1_busy_issue", busy_a, 1);
    chk("t1_wren_read", wren_a, 0);
    repeat (2) @(posedge clk); #1;

    // Write then read-back
    hs(0, 1, 1, 32'h20, 32'hCAFE0001, 32'h0, 1, t, w);
    @(negedge clk);
    chk("t2_wren_issue", wren_a, 1);
    chk("t2_ram_address", ramad_a, 8);
    chk("t2_ram_data", ramd_a, 32'hCAFE0001);
    @(negedge clk);
    chk("t2_wren_one_cycle", wren_a, 0);
    @(posedge clk); #1;
    hs(0, 1, 0, 32'h20, 32'h0, 32'hCAFE0001, 1, t, w);
    repeat (3) @(posedge clk); #1;

    // Contention: req0 has three reads, req1 one
    we_a = '0;
    addr_a[31:0] = 32'h10;
    addr_a[63:32] = 32'h14;
    rem[0] = 3; rem[1] = 1;
    vld_a = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; n = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        if (rdy_a != 2'b00) got = 1'b1;
        else n++;
      end
      chk($sformatf("t3_grant%0d", k), rdy_a, 2'b01 << win[k]);
      if (k > 0) chk($sformatf("t3_overlap%0d", k), cyc, prev + 2);
      prev = cyc;
      if (got) begin
        e.cyc  = cyc + 2;
        e.own  = 2'b01 << win[k];
        e.data = (win[k] == 0) ? 32'hDEADBEEF : 32'h55AA55AA;
        qa.push_back(e);
      end
      win_act = rdy_a[0] ? 0 : 1;
      @(posedge clk); #1;
      if (got) begin
        rem[win_act] = rem[win_act] - 1;
        if (rem[win_act] <= 0) vld_a[win_act] = 1'b0;
      end
    end
    vld_a = '0;
    repeat (3) @(posedge clk); #1;

    // Byte offset ignored
    hs(0, 0, 0, 32'h13, 32'h0, 32'hDEADBEEF, 1, t, w);
    @(negedge clk);
    chk("t6_ram_address", ramad_a, 4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_idle_ready", rdy_a, 0);
    chk("t6_idle_busy", busy_a, 0);
    chk("t6_addr_held", ramad_a, 4);
    @(posedge clk); #1;

    // Latency 3: ready stays low through ISSUE/WAIT, new grant in RESP
    hs(1, 0, 0, 32'h10, 32'h0, 32'h12345678, 1, t, w);
    we_b[1] = 1'b0;
    addr_b[63:32] = 32'h14;
    vld_b[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_ready_low%0d", k), rdy_b, 0);
    end
    @(negedge clk);
    chk("t4_regrant", rdy_b, 2'b10);
    chk("t4_regrant_cycle", cyc, t + 4);
    if (rdy_b == 2'b10) begin
      e.cyc = cyc + 4; e.own = 2'b10; e.data = 32'h0BADF00D;
      qb.push_back(e);
    end
    @(posedge clk); #1;
    vld_b[1] = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Reset while waiting for read data
    hs(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, t, w);
    @(posedge clk); #1;
    rstn_b = 1'b0;
    @(posedge clk); #1;
    rstn_b = 1'b1;
    @(negedge clk);
    chk("t5_rsp_valid", rspv_b, 0);
    chk("t5_busy", busy_b, 0);
    chk("t5_wren", wren_b, 0);
    chk("t5_ram_address", ramad_b, 0);
    chk("t5_ram_data", ramd_b, 0);
    chk("t5_rdata", rdata_b, 0);
    chk("t5_ready", rdy_b, 0);
    repeat (6) @(posedge clk); #1;
    hs(1, 1, 0, 32'h14, 32'h0, 32'h0BADF00D, 1, t, w);
    repeat (8) @(posedge clk);
    @(negedge clk);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
